// File: rtl/fram_pkg.sv
// -----------------------------------------------------------------------------
// fram_pkg
// Shared definitions for the FM24CLxx-style FRAM responder:
//   state_t    - responder FSM states
//   DEV_TYPE   - I2C device-type nibble matched on address[6:3]
//   addr_width - byte count to word-address width (ceil(log2))
// -----------------------------------------------------------------------------
package fram_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WR_DATA,
        RD_FETCH,
        RD_DATA
    } state_t;

    localparam logic [3:0] DEV_TYPE = 4'b1010;

    function automatic int unsigned addr_width(input int unsigned bytes);
        int unsigned w;
        w = 0;
        for (int unsigned i = 0; i < 16; i++) begin
            if ((32'd1 << i) < bytes) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/fram_mem.sv
// -----------------------------------------------------------------------------
// fram_mem
// Single-port synchronous RAM, one-cycle read latency, contents not reset.
// Ports:
//   clk    - rising-edge clock
//   en     - access enable (read when we=0, write when we=1)
//   we     - write enable
//   addr   - word address
//   wdata  - write byte
//   rdata  - registered read byte, updated only on enabled reads
// -----------------------------------------------------------------------------
module fram_mem #(
    parameter int unsigned DEPTH = 2048,
    parameter int unsigned AW    = 11
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [7:0]    wdata,
    output logic [7:0]    rdata
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/axis_fram_responder.sv
// -----------------------------------------------------------------------------
// axis_fram_responder
// Emulates an FM24CLxx I2C FRAM behind an AXI-Stream I2C-master command/data
// interface. A start-flagged write loads the word-address low byte; further
// write bytes are stored at an auto-incrementing, wrapping pointer. Reads
// return one byte per command from the pointer.
// Optional feature: define AXIS_FRAM_RESP_WRITE_PROTECT_EN to add the wp
// input; with wp=1 data bytes are consumed but not stored.
// Ports:
//   clk, rst                       - clock, async active-low reset
//   s_axis_cmd_*                   - command (address + flags) with handshake
//   s_axis_data_*                  - write data sink
//   m_axis_data_*                  - read data source
//   busy                           - FSM not idle
//   missed_ack                     - pulse on accepted non-matching address
//   wp (optional)                  - write protect
// -----------------------------------------------------------------------------
module axis_fram_responder
    import fram_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 2048,
    parameter logic [2:0]  DEV_ADDR  = 3'b000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] s_axis_cmd_address,
    input  logic       s_axis_cmd_start,
    input  logic       s_axis_cmd_read,
    input  logic       s_axis_cmd_write,
    input  logic       s_axis_cmd_write_multiple,
    input  logic       s_axis_cmd_stop,
    input  logic       s_axis_cmd_valid,
    output logic       s_axis_cmd_ready,
    input  logic [7:0] s_axis_data_tdata,
    input  logic       s_axis_data_tvalid,
    input  logic       s_axis_data_tlast,
    output logic       s_axis_data_tready,
    output logic [7:0] m_axis_data_tdata,
    output logic       m_axis_data_tvalid,
    output logic       m_axis_data_tlast,
    input  logic       m_axis_data_tready,
`ifdef AXIS_FRAM_RESP_WRITE_PROTECT_EN
    input  logic       wp,
`endif
    output logic       busy,
    output logic       missed_ack
);

    localparam int unsigned AW = addr_width(MEM_BYTES);
    localparam logic [AW-1:0] PTR_ONE = 1;

    state_t state, state_nx;

    logic [AW-1:0] ptr;
    logic          marker;     // next accepted write byte is the word-address
    logic          matched_q;
    logic          multi_q;
    logic          stop_q;
    logic [2:0]    hi_q;       // word-address bits above bit 7 from the I2C address

    logic          addr_match;
    logic          cmd_fire;
    logic          data_fire;
    logic          rd_fire;
    logic          wr_done;
    logic          protect;
    logic          mem_en;
    logic          mem_we;
    logic [7:0]    mem_rdata;
    logic [10:0]   load_addr;

`ifdef AXIS_FRAM_RESP_WRITE_PROTECT_EN
    assign protect = wp;
`else
    assign protect = 1'b0;
`endif

    assign addr_match = (s_axis_cmd_address[6:3] == DEV_TYPE) &&
                        ((MEM_BYTES != 256) || (s_axis_cmd_address[2:0] == DEV_ADDR));

    assign cmd_fire  = s_axis_cmd_valid & s_axis_cmd_ready;
    assign data_fire = s_axis_data_tvalid & s_axis_data_tready;
    assign rd_fire   = m_axis_data_tvalid & m_axis_data_tready;
    assign wr_done   = data_fire & (~multi_q | s_axis_data_tlast);
    assign load_addr = {hi_q, s_axis_data_tdata};

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx           = state;
        s_axis_cmd_ready   = 1'b0;
        s_axis_data_tready = 1'b0;
        m_axis_data_tvalid = 1'b0;
        m_axis_data_tlast  = 1'b0;
        missed_ack         = 1'b0;
        busy               = 1'b1;
        case (state)
            IDLE: begin
                busy             = 1'b0;
                s_axis_cmd_ready = 1'b1;
                if (s_axis_cmd_valid) begin
                    missed_ack = ~addr_match;
                    if (s_axis_cmd_read) begin
                        state_nx = RD_FETCH;
                    end else if (s_axis_cmd_write_multiple || s_axis_cmd_write) begin
                        state_nx = WR_DATA;
                    end
                end
            end
            WR_DATA: begin
                s_axis_data_tready = 1'b1;
                if (wr_done) begin
                    state_nx = IDLE;
                end
            end
            RD_FETCH: begin
                state_nx = RD_DATA;
            end
            RD_DATA: begin
                m_axis_data_tvalid = 1'b1;
                m_axis_data_tlast  = 1'b1;
                if (m_axis_data_tready) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // ----------------------------------------------------------- datapath
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr       <= '0;
            marker    <= 1'b0;
            matched_q <= 1'b0;
            multi_q   <= 1'b0;
            stop_q    <= 1'b0;
            hi_q      <= '0;
        end else begin
            if (cmd_fire) begin
                matched_q <= addr_match;
                multi_q   <= s_axis_cmd_write_multiple;
                stop_q    <= s_axis_cmd_stop;
                if (addr_match) begin
                    hi_q <= s_axis_cmd_address[2:0];
                    if (s_axis_cmd_start && !s_axis_cmd_read &&
                        (s_axis_cmd_write || s_axis_cmd_write_multiple)) begin
                        marker <= 1'b1;
                    end
                end
            end

            if (state == WR_DATA && data_fire && matched_q) begin
                if (marker) begin
                    ptr    <= load_addr[AW-1:0];
                    marker <= 1'b0;
                end else begin
                    ptr <= ptr + PTR_ONE;
                end
            end

            if (rd_fire && matched_q) begin
                ptr <= ptr + PTR_ONE;
            end

            if ((state == WR_DATA && wr_done) || rd_fire) begin
                if (stop_q) begin
                    marker <= 1'b0;
                end
            end
        end
    end

    assign mem_we = (state == WR_DATA) & data_fire & matched_q & ~marker & ~protect;
    assign mem_en = mem_we | (state == RD_FETCH);

    fram_mem #(
        .DEPTH (MEM_BYTES),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .en    (mem_en),
        .we    (mem_we),
        .addr  (ptr),
        .wdata (s_axis_data_tdata),
        .rdata (mem_rdata)
    );

    // Non-matching reads return idle-bus value; RAM output is stable in RD_DATA.
    assign m_axis_data_tdata = (state != RD_DATA) ? 8'h00 :
                               (matched_q ? mem_rdata : 8'hFF);

endmodule

// File: tb/tb_axis_fram_responder.sv
// -----------------------------------------------------------------------------
// tb_axis_fram_responder
// Directed-vector bench for axis_fram_responder (default MEM_BYTES=2048).
// -----------------------------------------------------------------------------
module tb_axis_fram_responder;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] s_axis_cmd_address;
    logic       s_axis_cmd_start;
    logic       s_axis_cmd_read;
    logic       s_axis_cmd_write;
    logic       s_axis_cmd_write_multiple;
    logic       s_axis_cmd_stop;
    logic       s_axis_cmd_valid;
    logic       s_axis_cmd_ready;
    logic [7:0] s_axis_data_tdata;
    logic       s_axis_data_tvalid;
    logic       s_axis_data_tlast;
    logic       s_axis_data_tready;
    logic [7:0] m_axis_data_tdata;
    logic       m_axis_data_tvalid;
    logic       m_axis_data_tlast;
    logic       m_axis_data_tready;
`ifdef AXIS_FRAM_RESP_WRITE_PROTECT_EN
    logic       wp;
`endif
    logic       busy;
    logic       missed_ack;

    int checks   = 0;
    int failures = 0;
    logic last_miss;

    always #5 clk = ~clk;

    axis_fram_responder #(
        .MEM_BYTES (2048),
        .DEV_ADDR  (3'b000)
    ) dut (
        .clk                       (clk),
        .rst                       (rst),
        .s_axis_cmd_address        (s_axis_cmd_address),
        .s_axis_cmd_start          (s_axis_cmd_start),
        .s_axis_cmd_read           (s_axis_cmd_read),
        .s_axis_cmd_write          (s_axis_cmd_write),
        .s_axis_cmd_write_multiple (s_axis_cmd_write_multiple),
        .s_axis_cmd_stop           (s_axis_cmd_stop),
        .s_axis_cmd_valid          (s_axis_cmd_valid),
        .s_axis_cmd_ready          (s_axis_cmd_ready),
        .s_axis_data_tdata         (s_axis_data_tdata),
        .s_axis_data_tvalid        (s_axis_data_tvalid),
        .s_axis_data_tlast         (s_axis_data_tlast),
        .s_axis_data_tready        (s_axis_data_tready),
        .m_axis_data_tdata         (m_axis_data_tdata),
        .m_axis_data_tvalid        (m_axis_data_tvalid),
        .m_axis_data_tlast         (m_axis_data_tlast),
        .m_axis_data_tready        (m_axis_data_tready),
`ifdef AXIS_FRAM_RESP_WRITE_PROTECT_EN
        .wp                        (wp),
`endif
        .busy                      (busy),
        .missed_ack                (missed_ack)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_cmd(input logic [6:0] a, input logic st, input logic rd,
                            input logic wr, input logic wm, input logic sp);
        int n;
        n = 0;
        @(negedge clk);
        s_axis_cmd_address        = a;
        s_axis_cmd_start          = st;
        s_axis_cmd_read           = rd;
        s_axis_cmd_write          = wr;
        s_axis_cmd_write_multiple = wm;
        s_axis_cmd_stop           = sp;
        s_axis_cmd_valid          = 1'b1;
        #1;
        while (!s_axis_cmd_ready && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("cmd_ready", 32'(s_axis_cmd_ready), 32'd1);
        last_miss = missed_ack;
        @(posedge clk);
        #1;
        s_axis_cmd_valid          = 1'b0;
        s_axis_cmd_start          = 1'b0;
        s_axis_cmd_read           = 1'b0;
        s_axis_cmd_write          = 1'b0;
        s_axis_cmd_write_multiple = 1'b0;
        s_axis_cmd_stop           = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic l);
        int n;
        n = 0;
        @(negedge clk);
        s_axis_data_tdata  = d;
        s_axis_data_tlast  = l;
        s_axis_data_tvalid = 1'b1;
        #1;
        while (!s_axis_data_tready && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("data_ready", 32'(s_axis_data_tready), 32'd1);
        @(posedge clk);
        #1;
        s_axis_data_tvalid = 1'b0;
        s_axis_data_tlast  = 1'b0;
    endtask

    // Called #1 after the command-acceptance edge.
    task automatic do_read(input string tag, input logic [7:0] exp, input int hold);
        check({tag, "_fetch_tvalid"}, 32'(m_axis_data_tvalid), 32'd0);
        @(posedge clk);
        #1;
        check({tag, "_tvalid"}, 32'(m_axis_data_tvalid), 32'd1);
        check({tag, "_tdata"},  32'(m_axis_data_tdata),  32'(exp));
        check({tag, "_tlast"},  32'(m_axis_data_tlast),  32'd1);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check({tag, "_hold_tvalid"}, 32'(m_axis_data_tvalid), 32'd1);
            check({tag, "_hold_tdata"},  32'(m_axis_data_tdata),  32'(exp));
        end
        m_axis_data_tready = 1'b1;
        @(posedge clk);
        #1;
        m_axis_data_tready = 1'b0;
        check({tag, "_busy_after"}, 32'(busy), 32'd0);
    endtask

    initial begin
        rst                       = 1'b0;
        s_axis_cmd_address        = '0;
        s_axis_cmd_start          = 1'b0;
        s_axis_cmd_read           = 1'b0;
        s_axis_cmd_write          = 1'b0;
        s_axis_cmd_write_multiple = 1'b0;
        s_axis_cmd_stop           = 1'b0;
        s_axis_cmd_valid          = 1'b0;
        s_axis_data_tdata         = '0;
        s_axis_data_tvalid        = 1'b0;
        s_axis_data_tlast         = 1'b0;
        m_axis_data_tready        = 1'b0;
`ifdef AXIS_FRAM_RESP_WRITE_PROTECT_EN
        wp                        = 1'b0;
`endif
        last_miss                 = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy",   32'(busy),               32'd0);
        check("rst_tvalid", 32'(m_axis_data_tvalid), 32'd0);
        check("rst_dready", 32'(s_axis_data_tready), 32'd0);
        check("rst_miss",   32'(missed_ack),         32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("idle_cmd_ready", 32'(s_axis_cmd_ready), 32'd1);
        check("idle_ptr",       32'(dut.ptr),          32'd0);

        // start+write_multiple: address byte 04, data AA
        send_cmd(7'h50, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        check("wm_miss", 32'(last_miss), 32'd0);
        check("wm_busy", 32'(busy), 32'd1);
        send_byte(8'h04, 1'b0);
        send_byte(8'hAA, 1'b1);
        check("wm_mem4", 32'(dut.u_mem.mem[4]), 32'hAA);
        check("wm_ptr",  32'(dut.ptr),          32'd5);
        check("wm_busy_after", 32'(busy),       32'd0);

        // start+write sets pointer only, then read with backpressure
        send_cmd(7'h50, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        send_byte(8'h04, 1'b0);
        check("w_ptr",  32'(dut.ptr), 32'd4);
        check("w_busy", 32'(busy),    32'd0);
        send_cmd(7'h50, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        do_read("rd1", 8'hAA, 5);
        check("rd1_ptr", 32'(dut.ptr), 32'd5);

        // Pointer wrap at the top of the array
        send_cmd(7'h57, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        send_byte(8'hFF, 1'b0);
        check("wrap_ptr_load", 32'(dut.ptr), 32'd2047);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b1);
        check("wrap_mem2047", 32'(dut.u_mem.mem[2047]), 32'h11);
        check("wrap_mem0",    32'(dut.u_mem.mem[0]),    32'h22);
        check("wrap_ptr",     32'(dut.ptr),             32'd1);

        // Priority: read beats write flags
        send_cmd(7'h50, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        send_byte(8'h04, 1'b0);
        send_cmd(7'h50, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        check("prio_rd_dready", 32'(s_axis_data_tready), 32'd0);
        do_read("prio", 8'hAA, 0);
        check("prio_ptr", 32'(dut.ptr), 32'd5);

        // Priority: write_multiple beats write (continues past first data byte)
        send_cmd(7'h50, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        send_byte(8'h06, 1'b0);
        send_byte(8'h33, 1'b0);
        check("prio_wm_busy", 32'(busy), 32'd1);
        send_byte(8'h44, 1'b1);
        check("prio_mem6", 32'(dut.u_mem.mem[6]), 32'h33);
        check("prio_mem7", 32'(dut.u_mem.mem[7]), 32'h44);
        check("prio_ptr8", 32'(dut.ptr),          32'd8);

        // Command with no read/write flag stays idle
        send_cmd(7'h50, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        check("noop_busy", 32'(busy), 32'd0);

        // Non-matching address
        send_cmd(7'h60, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        check("nm_miss", 32'(last_miss), 32'd1);
        do_read("nm_rd", 8'hFF, 1);
        check("nm_rd_ptr", 32'(dut.ptr), 32'd8);
        send_cmd(7'h60, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        check("nm_wr_miss", 32'(last_miss), 32'd1);
        send_byte(8'h04, 1'b0);
        send_byte(8'h55, 1'b1);
        check("nm_wr_busy", 32'(busy),              32'd0);
        check("nm_mem4",    32'(dut.u_mem.mem[4]),  32'hAA);
        check("nm_ptr",     32'(dut.ptr),           32'd8);

        // Reset while a read byte is presented
        send_cmd(7'h50, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        send_byte(8'h04, 1'b0);
        send_cmd(7'h50, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        check("rr_tvalid_pre", 32'(m_axis_data_tvalid), 32'd1);
        rst = 1'b0;
        #1;
        check("rr_tvalid_rst", 32'(m_axis_data_tvalid), 32'd0);
        check("rr_busy_rst",   32'(busy),               32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rr_cmd_ready", 32'(s_axis_cmd_ready),   32'd1);
        check("rr_ptr",       32'(dut.ptr),            32'd0);
        check("rr_mem4",      32'(dut.u_mem.mem[4]),   32'hAA);
        check("rr_tvalid",    32'(m_axis_data_tvalid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
